// File: rtl/alu_seq.sv
// Registered W-bit ALU with Z/N/C/V flags and a start/busy/done handshake.
// Logic ops, add/sub and shifts finish in one clock; shift-and-add multiply takes W clocks.
module alu_seq #(
  parameter int W      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [2:0]   afs,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         z,
  output logic         n,
  output logic         c,
  output logic         v,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0]   IDLE    = 1'b0;
  localparam logic [0:0]   MUL     = 1'b1;
  localparam logic [W-1:0] LAST    = W'(W - 1);
  localparam logic [W-1:0] WIDTH_V = W'(W);

  // Returns {carry, overflow, sum}; subtract is x + ~y + 1.
  function automatic logic [W+1:0] f_addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    logic [W-1:0] yy;
    logic [W:0]   sum;
    yy  = s ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    return {sum[W], (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]), sum[W-1:0]};
  endfunction

  // Returns {last bit shifted out, result}; zero amount passes x through with no carry.
  function automatic logic [W:0] f_shift(input logic [W-1:0] x, input logic [W-1:0] amt,
                                         input logic left);
    logic [2*W-1:0] ext;
    if (amt == '0) begin
      return {1'b0, x};
    end else if (amt >= WIDTH_V) begin
      return '0;
    end else if (left) begin
      ext = {{W{1'b0}}, x} << amt;
      return {ext[W], ext[W-1:0]};
    end else begin
      ext = {x, {W{1'b0}}} >> amt;
      return {ext[W-1], ext[2*W-1:W]};
    end
  endfunction

  logic [0:0]     state_q, state_d;
  logic [W-1:0]   res_q, res_d;
  logic           z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic           done_q, done_d;
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [W-1:0]   mplier_q, mplier_d, cnt_q, cnt_d;
  logic [W-1:0]   op_res;
  logic           op_c, op_v;

  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (afs)
      3'b000:  op_res = a ^ b;
      3'b001:  op_res = a & b;
      3'b010:  op_res = a | b;
      3'b011:  {op_c, op_v, op_res} = f_addsub(a, b, sub);
      3'b100:  {op_c, op_res} = f_shift(a, b, 1'b1);
      3'b101:  {op_c, op_res} = f_shift(a, b, 1'b0);
      default: ;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (MUL_EN && afs == 3'b110) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
          end else begin
            res_d  = op_res;
            z_d    = (op_res == '0);
            n_d    = op_res[W-1];
            c_d    = op_c;
            v_d    = op_v;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + W'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          res_d   = acc_step[W-1:0];
          z_d     = (acc_step[W-1:0] == '0);
          n_d     = acc_step[W-1];
          c_d     = |acc_step[2*W-1:W];
          v_d     = |acc_step[2*W-1:W];
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  // Multiplier working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    cnt_q    <= cnt_d;
  end

  assign res  = res_q;
  assign z    = z_q;
  assign n    = n_q;
  assign c    = c_q;
  assign v    = v_q;
  assign busy = (state_q == MUL);
  assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random operations checked against an arithmetic model,
// plus a second instance built without the multiplier.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, start0 = 1'b0, sub = 1'b0;
  logic [2:0]   afs = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] res, res0;
  logic         z, n, c, v, busy, done;
  logic         z0, n0, c0, v0, busy0, done0;
  int           errors = 0, checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .afs(afs), .a(a), .b(b),
    .res(res), .z(z), .n(n), .c(c), .v(v), .busy(busy), .done(done));

  alu_seq #(.W(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub), .afs(afs), .a(a), .b(b),
    .res(res0), .z(z0), .n(n0), .c(c0), .v(v0), .busy(busy0), .done(done0));

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on 8-bit unsigned values.
  task automatic model(input int op, input bit s, input int x, input int y,
                       output int r, output bit cf, output bit vf);
    int sx, sy, t;
    r  = 0;
    cf = 1'b0;
    vf = 1'b0;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    case (op)
      0: r = x ^ y;
      1: r = x & y;
      2: r = x | y;
      3: begin
        if (!s) begin
          t  = x + y;
          vf = (sx + sy > 127) || (sx + sy < -128);
        end else begin
          t  = x + (255 - y) + 1;
          vf = (sx - sy > 127) || (sx - sy < -128);
        end
        r  = t % 256;
        cf = (t >= 256);
      end
      4: begin
        if (y == 0) r = x;
        else if (y < W) begin
          r  = (x << y) % 256;
          cf = (((x >> (W - y)) & 1) == 1);
        end
      end
      5: begin
        if (y == 0) r = x;
        else if (y < W) begin
          r  = x >> y;
          cf = (((x >> (y - 1)) & 1) == 1);
        end
      end
      6: begin
        t  = x * y;
        r  = t % 256;
        cf = (t >= 256);
        vf = cf;
      end
      default: r = 0;
    endcase
  endtask

  task automatic check_out(input string tag, input int er, input bit ec, input bit ev);
    chk({tag, ".res"},  int'(res),  er);
    chk({tag, ".z"},    int'(z),    int'(er == 0));
    chk({tag, ".n"},    int'(n),    int'(er >= 128));
    chk({tag, ".c"},    int'(c),    int'(ec));
    chk({tag, ".v"},    int'(v),    int'(ev));
    chk({tag, ".done"}, int'(done), 1);
  endtask

  task automatic issue(input int op, input bit s, input int x, input int y);
    @(negedge clk);
    afs   = 3'(op);
    sub   = s;
    a     = 8'(x);
    b     = 8'(y);
    start = 1'b1;
  endtask

  task automatic run_single(input string tag, input int op, input bit s, input int x, input int y);
    int r;
    bit cf, vf;
    issue(op, s, x, y);
    @(posedge clk);
    #1;
    model(op, s, x, y, r, cf, vf);
    check_out(tag, r, cf, vf);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".done_low"}, int'(done), 0);
  endtask

  task automatic run_mul(input string tag, input int x, input int y, input bit inject);
    int r, prev;
    bit cf, vf;
    prev = int'(res);
    issue(6, 1'b0, x, y);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy_start"}, int'(busy), 1);
    chk({tag, ".done_start"}, int'(done), 0);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      start = inject && (i < W - 1) && (i % 2 == 0);
      if (inject) begin
        afs = 3'b000;
        a   = 8'hFF;
      end
      @(posedge clk);
      #1;
      chk({tag, ".busy"}, int'(busy), 1);
      chk({tag, ".hold"}, int'(res), prev);
      if (done !== 1'b0) chk({tag, ".early_done"}, int'(done), 0);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    model(6, 1'b0, x, y, r, cf, vf);
    check_out(tag, r, cf, vf);
    chk({tag, ".busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int op, x, y;

    #12;
    chk("rst.res", int'(res), 0);
    chk("rst.flags", int'({z, n, c, v}), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_single("add7f", 3, 1'b0, 8'h7F, 8'h01);
    idle("add7f");
    run_single("sub_eq", 3, 1'b1, 8'h05, 8'h05);
    run_single("sub_brw", 3, 1'b1, 8'h00, 8'h01);
    idle("sub");

    run_mul("mul_0d0b", 8'h0D, 8'h0B, 1'b1);
    idle("mul_0d0b");
    run_mul("mul_1010", 8'h10, 8'h10, 1'b0);
    idle("mul_1010");

    run_single("shl1", 4, 1'b0, 8'h81, 1);
    run_single("shr1", 5, 1'b0, 8'h81, 1);
    run_single("shr8", 5, 1'b0, 8'h81, 8);
    run_single("shl0", 4, 1'b0, 8'h81, 0);
    run_single("rsvd", 7, 1'b0, 8'h55, 8'h0F);
    run_single("shl0b", 4, 1'b0, 8'h81, 0);
    idle("shift");

    issue(6, 1'b0, 8'h0D, 8'h0B);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.res", int'(res), 0);
    chk("abort.flags", int'({z, n, c, v}), 0);
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.no_done", int'(done), 0);
    run_single("xor_after_rst", 0, 1'b0, 8'hF0, 8'hFF);
    idle("xor_after_rst");

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 7));
      x  = int'($urandom_range(0, 255));
      y  = (op == 4 || op == 5) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
      if (op == 6) run_mul("rnd_mul", x, y, 1'b0);
      else         run_single("rnd", op, 1'(($urandom_range(0, 1))), x, y);
    end
    idle("rnd");

    @(negedge clk);
    afs    = 3'b000;
    a      = 8'h03;
    b      = 8'h05;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    chk("nomul.xor", int'(res0), 8'h06);
    @(negedge clk);
    afs = 3'b110;
    b   = 8'h03;
    @(posedge clk);
    #1;
    chk("nomul.mul_res", int'(res0), 0);
    chk("nomul.mul_flags", int'({z0, n0, c0, v0}), 4'b1000);
    chk("nomul.mul_done", int'(done0), 1);
    chk("nomul.mul_busy", int'(busy0), 0);
    @(negedge clk);
    afs = 3'b000;
    @(posedge clk);
    #1;
    chk("nomul.xor2", int'(res0), 0);
    @(negedge clk);
    afs = 3'b111;
    b   = 8'h05;
    @(posedge clk);
    #1;
    chk("nomul.rsvd_res", int'(res0), 0);
    chk("nomul.rsvd_flags", int'({z0, n0, c0, v0}), 4'b1000);
    chk("nomul.rsvd_done", int'(done0), 1);
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("nomul.idle_busy", int'(busy0), 0);
      chk("nomul.idle_done", int'(done0), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
